// File: rtl/viterbi_fifo_read_controller.sv
`default_nettype none
// ============================================================================
// Module      : viterbi_fifo_read_controller
// Description : Drains the Viterbi chunk FIFO bank in strict round-robin
//               order. Each head entry is handed to the Viterbi engine, and
//               the entry is popped once the engine reports completion.
// Revision    : 1.0 - initial release
// ============================================================================
module viterbi_fifo_read_controller #(
  parameter int NUM_OF_CHUNKS        = 5,
  parameter int NUM_OF_VITERBI_FIFOS = 4,
  parameter int COUNT_WIDTH          = 16,
  localparam int LW = (NUM_OF_CHUNKS > 1) ? $clog2(NUM_OF_CHUNKS) : 1,
  localparam int PW = $clog2(NUM_OF_VITERBI_FIFOS)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            i_en_fifo,
  input  logic [NUM_OF_VITERBI_FIFOS-1:0] i_empty,
  input  logic [LW-1:0]                   i_fifo_start_loc [NUM_OF_VITERBI_FIFOS-1:0],
  input  logic                            i_viterbi_done,
  output logic                            o_init_n,
  output logic [NUM_OF_VITERBI_FIFOS-1:0] o_pop_n,
  output logic                            o_viterbi_start,
  output logic [PW-1:0]                   o_viterbi_fifo_sel,
  output logic [LW-1:0]                   o_viterbi_start_loc,
  output logic                            o_busy,
  output logic [COUNT_WIDTH-1:0]          o_read_count
);

  localparam logic [PW-1:0] c_ptr_last = PW'(NUM_OF_VITERBI_FIFOS - 1);
  localparam logic [PW-1:0] c_ptr_one  = PW'(1);
  localparam logic [COUNT_WIDTH-1:0] c_cnt_one = COUNT_WIDTH'(1);
  localparam logic [NUM_OF_VITERBI_FIFOS-1:0] c_onehot0 =
    {{(NUM_OF_VITERBI_FIFOS-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_BUSY = 2'd2
  } state_t;

  state_t                          r_state, w_state_nxt;
  logic [PW-1:0]                   r_ptr, w_ptr_nxt, w_ptr_inc;
  logic [COUNT_WIDTH-1:0]          r_read_count, w_read_count_nxt;
  logic                            r_start, w_start_nxt;
  logic [PW-1:0]                   r_sel, w_sel_nxt;
  logic [LW-1:0]                   r_loc, w_loc_nxt;
  logic                            r_busy, w_busy_nxt;
  logic [NUM_OF_VITERBI_FIFOS-1:0] r_pop_n, w_pop_n_nxt;
  logic                            w_init_n;

  // Explicit wrap so non-power-of-two FIFO counts never index past the bank.
  assign w_ptr_inc = (r_ptr == c_ptr_last) ? '0 : (r_ptr + c_ptr_one);

  // State register and registered outputs; reset aborts any in-flight entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_ptr        <= '0;
      r_read_count <= '0;
      r_start      <= 1'b0;
      r_sel        <= '0;
      r_loc        <= '0;
      r_busy       <= 1'b0;
      r_pop_n      <= '1;
    end else begin
      r_state      <= w_state_nxt;
      r_ptr        <= w_ptr_nxt;
      r_read_count <= w_read_count_nxt;
      r_start      <= w_start_nxt;
      r_sel        <= w_sel_nxt;
      r_loc        <= w_loc_nxt;
      r_busy       <= w_busy_nxt;
      r_pop_n      <= w_pop_n_nxt;
    end
  end

  // Next-state and next-output logic; start and pop are single-cycle strobes.
  always_comb begin
    w_state_nxt      = r_state;
    w_ptr_nxt        = r_ptr;
    w_read_count_nxt = r_read_count;
    w_start_nxt      = 1'b0;
    w_sel_nxt        = r_sel;
    w_loc_nxt        = r_loc;
    w_busy_nxt       = r_busy;
    w_pop_n_nxt      = '1;
    w_init_n         = 1'b1;
    case (r_state)
      S_IDLE: begin
        w_busy_nxt = 1'b0;
        if (i_en_fifo) begin
          w_init_n         = 1'b0;
          w_ptr_nxt        = '0;
          w_read_count_nxt = '0;
          w_state_nxt      = S_WAIT;
        end
      end
      S_WAIT: begin
        w_busy_nxt = 1'b0;
        if (!i_en_fifo) begin
          w_state_nxt = S_IDLE;
        end else if (!i_empty[r_ptr]) begin
          w_start_nxt = 1'b1;
          w_sel_nxt   = r_ptr;
          w_loc_nxt   = i_fifo_start_loc[r_ptr];
          w_busy_nxt  = 1'b1;
          w_state_nxt = S_BUSY;
        end
      end
      S_BUSY: begin
        // A disable here is deferred: the entry still completes and pops.
        if (i_viterbi_done) begin
          w_pop_n_nxt      = ~(c_onehot0 << r_ptr);
          w_ptr_nxt        = w_ptr_inc;
          w_read_count_nxt = r_read_count + c_cnt_one;
          w_busy_nxt       = 1'b0;
          w_state_nxt      = i_en_fifo ? S_WAIT : S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Only init_n is combinational; it is held inactive while reset is applied.
  assign o_init_n            = w_init_n | ~rst_n;
  assign o_pop_n             = r_pop_n;
  assign o_viterbi_start     = r_start;
  assign o_viterbi_fifo_sel  = r_sel;
  assign o_viterbi_start_loc = r_loc;
  assign o_busy              = r_busy;
  assign o_read_count        = r_read_count;

endmodule
`default_nettype wire

// File: tb/tb_viterbi_fifo_read_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_viterbi_fifo_read_controller
// Description : Scoreboard bench for the Viterbi FIFO read controller. One
//               instance uses N=4 / 16-bit count, the other N=3 / 4-bit count.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_viterbi_fifo_read_controller;

  logic clk;
  logic rst_n;

  // Instance A: N=4, count_width=16
  logic       en_a, done_a, init_a, start_a, busy_a;
  logic [3:0] empty_a, pop_a;
  logic [2:0] loc_a [3:0];
  logic [1:0] sel_a;
  logic [2:0] sloc_a;
  logic [15:0] cnt_a;

  // Instance B: N=3, count_width=4
  logic       en_b, done_b, init_b, start_b, busy_b;
  logic [2:0] empty_b, pop_b;
  logic [2:0] loc_b [2:0];
  logic [1:0] sel_b;
  logic [2:0] sloc_b;
  logic [3:0] cnt_b;

  int errors = 0;
  int checks = 0;
  int n_start_a = 0;
  int n_start_b = 0;
  bit auto_a = 0;
  bit auto_b = 0;
  int lat_a = 3;
  int lat_b = 1;

  logic [4:0]  exp_start_a [$];
  logic [19:0] exp_pop_a   [$];
  logic [4:0]  exp_start_b [$];
  logic [6:0]  exp_pop_b   [$];

  viterbi_fifo_read_controller #(
    .NUM_OF_CHUNKS(5), .NUM_OF_VITERBI_FIFOS(4), .COUNT_WIDTH(16)
  ) u_dut_a (
    .clk(clk), .rst_n(rst_n), .i_en_fifo(en_a), .i_empty(empty_a),
    .i_fifo_start_loc(loc_a), .i_viterbi_done(done_a), .o_init_n(init_a),
    .o_pop_n(pop_a), .o_viterbi_start(start_a), .o_viterbi_fifo_sel(sel_a),
    .o_viterbi_start_loc(sloc_a), .o_busy(busy_a), .o_read_count(cnt_a)
  );

  viterbi_fifo_read_controller #(
    .NUM_OF_CHUNKS(5), .NUM_OF_VITERBI_FIFOS(3), .COUNT_WIDTH(4)
  ) u_dut_b (
    .clk(clk), .rst_n(rst_n), .i_en_fifo(en_b), .i_empty(empty_b),
    .i_fifo_start_loc(loc_b), .i_viterbi_done(done_b), .o_init_n(init_b),
    .o_pop_n(pop_b), .o_viterbi_start(start_b), .o_viterbi_fifo_sel(sel_b),
    .o_viterbi_start_loc(sloc_b), .o_busy(busy_b), .o_read_count(cnt_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Scoreboard monitor for instance A
  initial begin : g_mon_a
    logic [4:0]  es;
    logic [19:0] ep;
    forever begin
      @(negedge clk);
      if (start_a === 1'b1) begin
        n_start_a++;
        checks++;
        if (exp_start_a.size() == 0) begin
          errors++;
          $display("FAIL a_start_unexpected: got sel=%0d loc=%0d, required no start", sel_a, sloc_a);
        end else begin
          es = exp_start_a.pop_front();
          if ({sel_a, sloc_a} !== es) begin
            errors++;
            $display("FAIL a_start: got sel=%0d loc=%0d, required sel=%0d loc=%0d", sel_a, sloc_a, es[4:3], es[2:0]);
          end
        end
      end
      if (pop_a !== 4'hF) begin
        checks++;
        if (exp_pop_a.size() == 0) begin
          errors++;
          $display("FAIL a_pop_unexpected: got pop_n=%b, required 1111", pop_a);
        end else begin
          ep = exp_pop_a.pop_front();
          if ({pop_a, cnt_a} !== ep) begin
            errors++;
            $display("FAIL a_pop: got pop_n=%b count=%0d, required pop_n=%b count=%0d", pop_a, cnt_a, ep[19:16], ep[15:0]);
          end
        end
      end
    end
  end

  // Scoreboard monitor for instance B, plus one-low check on every pop
  initial begin : g_mon_b
    logic [4:0] es;
    logic [6:0] ep;
    forever begin
      @(negedge clk);
      if (start_b === 1'b1) begin
        n_start_b++;
        checks++;
        if (exp_start_b.size() == 0) begin
          errors++;
          $display("FAIL b_start_unexpected: got sel=%0d loc=%0d, required no start", sel_b, sloc_b);
        end else begin
          es = exp_start_b.pop_front();
          if ({sel_b, sloc_b} !== es) begin
            errors++;
            $display("FAIL b_start: got sel=%0d loc=%0d, required sel=%0d loc=%0d", sel_b, sloc_b, es[4:3], es[2:0]);
          end
        end
      end
      if (pop_b !== 3'b111) begin
        checks++;
        if ($countones(~pop_b) != 1) begin
          errors++;
          $display("FAIL b_pop_onelow: got pop_n=%b, required exactly one low bit", pop_b);
        end
        checks++;
        if (exp_pop_b.size() == 0) begin
          errors++;
          $display("FAIL b_pop_unexpected: got pop_n=%b, required 111", pop_b);
        end else begin
          ep = exp_pop_b.pop_front();
          if ({pop_b, cnt_b} !== ep) begin
            errors++;
            $display("FAIL b_pop: got pop_n=%b count=%0d, required pop_n=%b count=%0d", pop_b, cnt_b, ep[6:4], ep[3:0]);
          end
        end
      end
    end
  end

  // Engine models: done pulse a fixed number of cycles after each start
  initial begin : g_eng_a
    int c;
    c = 0;
    forever begin
      @(negedge clk);
      if (auto_a) begin
        done_a = 1'b0;
        if (c > 0) begin
          c--;
          if (c == 0) done_a = 1'b1;
        end
        if (start_a === 1'b1) c = lat_a;
      end else begin
        c = 0;
      end
    end
  end

  initial begin : g_eng_b
    int c;
    c = 0;
    forever begin
      @(negedge clk);
      if (auto_b) begin
        done_b = 1'b0;
        if (c > 0) begin
          c--;
          if (c == 0) done_b = 1'b1;
        end
        if (start_b === 1'b1) c = lat_b;
      end else begin
        c = 0;
      end
    end
  end

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic wait_drained(input string name, input int budget);
    int k;
    k = 0;
    while ((exp_start_a.size() + exp_pop_a.size() + exp_start_b.size() + exp_pop_b.size()) != 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (k >= budget) begin
      errors++;
      $display("FAIL %s_timeout: got %0d pending entries, required 0", name,
               exp_start_a.size() + exp_pop_a.size() + exp_start_b.size() + exp_pop_b.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    en_a = 1'b0; done_a = 1'b0; empty_a = 4'hF;
    en_b = 1'b0; done_b = 1'b0; empty_b = 3'b111;
    loc_a[0] = 3'd1; loc_a[1] = 3'd3; loc_a[2] = 3'd0; loc_a[3] = 3'd4;
    loc_b[0] = 3'd2; loc_b[1] = 3'd1; loc_b[2] = 3'd4;
    wait_cycles(3);
    checks++;
    if ({start_a, busy_a, sel_a, sloc_a, pop_a, init_a, cnt_a} !== {1'b0, 1'b0, 2'd0, 3'd0, 4'hF, 1'b1, 16'd0}) begin
      errors++;
      $display("FAIL reset_values: got start=%b busy=%b sel=%0d loc=%0d pop=%b init=%b cnt=%0d, required 0 0 0 0 1111 1 0",
               start_a, busy_a, sel_a, sloc_a, pop_a, init_a, cnt_a);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_init();
    checks++;
    if (init_a !== 1'b1) begin errors++; $display("FAIL init_idle_disabled: got %b, required 1", init_a); end
    en_a = 1'b1;
    #1;
    checks++;
    if (init_a !== 1'b0) begin errors++; $display("FAIL init_pulse: got %b, required 0", init_a); end
    @(negedge clk);
    checks++;
    if (init_a !== 1'b1) begin errors++; $display("FAIL init_one_cycle: got %b, required 1", init_a); end
    checks++;
    if ({busy_a, cnt_a} !== {1'b0, 16'd0}) begin
      errors++; $display("FAIL init_wait_state: got busy=%b cnt=%0d, required 0 0", busy_a, cnt_a);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] pops [5];
    int n0, k;
    pops[0] = 4'hE; pops[1] = 4'hD; pops[2] = 4'hB; pops[3] = 4'h7; pops[4] = 4'hE;
    for (int i = 0; i < 5; i++) begin
      exp_start_a.push_back({2'(i % 4), loc_a[i % 4]});
      exp_pop_a.push_back({pops[i], 16'(i + 1)});
    end
    n0 = n_start_a;
    auto_a = 1'b1;
    empty_a = 4'h0;
    k = 0;
    while (n_start_a < n0 + 5 && k < 200) begin @(negedge clk); k++; end
    empty_a = 4'hF;
    wait_drained("round_robin", 100);
  endtask

  task automatic test_empty_stall();
    int n0;
    empty_a = 4'b1011;
    n0 = n_start_a;
    wait_cycles(6);
    checks++;
    if (n_start_a != n0 || busy_a !== 1'b0) begin
      errors++; $display("FAIL stall_no_skip: got starts=%0d busy=%b, required starts=%0d busy=0", n_start_a, busy_a, n0);
    end
    exp_start_a.push_back({2'd1, 3'd3});
    exp_pop_a.push_back({4'hD, 16'd6});
    empty_a = 4'b1001;
    @(negedge clk);
    checks++;
    if ({start_a, sel_a} !== {1'b1, 2'd1}) begin
      errors++; $display("FAIL stall_latency: got start=%b sel=%0d, required start=1 sel=1", start_a, sel_a);
    end
    empty_a = 4'hF;
    wait_drained("stall", 100);
  endtask

  task automatic test_disable_busy();
    int k;
    auto_a = 1'b0;
    done_a = 1'b0;
    exp_start_a.push_back({2'd2, 3'd0});
    exp_pop_a.push_back({4'hB, 16'd7});
    empty_a = 4'b1011;
    k = 0;
    while (start_a !== 1'b1 && k < 50) begin @(negedge clk); k++; end
    empty_a = 4'hF;
    wait_cycles(2);
    en_a = 1'b0;
    wait_cycles(3);
    checks++;
    if ({busy_a, pop_a} !== {1'b1, 4'hF}) begin
      errors++; $display("FAIL disable_hold: got busy=%b pop=%b, required busy=1 pop=1111", busy_a, pop_a);
    end
    done_a = 1'b1;
    @(negedge clk);
    done_a = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy_a, init_a, pop_a} !== {1'b0, 1'b1, 4'hF}) begin
      errors++; $display("FAIL disable_idle: got busy=%b init=%b pop=%b, required 0 1 1111", busy_a, init_a, pop_a);
    end
    done_a = 1'b1;
    @(negedge clk);
    done_a = 1'b0;
    checks++;
    if ({pop_a, cnt_a} !== {4'hF, 16'd7}) begin
      errors++; $display("FAIL idle_done_ignored: got pop=%b cnt=%0d, required 1111 7", pop_a, cnt_a);
    end
    wait_drained("disable", 20);
  endtask

  task automatic test_non_pow2_wrap();
    int n0, k;
    en_b = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 17; i++) begin
      exp_start_b.push_back({2'(i % 3), loc_b[i % 3]});
      exp_pop_b.push_back({~(3'b001 << (i % 3)), 4'((i + 1) % 16)});
    end
    n0 = n_start_b;
    auto_b = 1'b1;
    empty_b = 3'b000;
    k = 0;
    while (n_start_b < n0 + 17 && k < 400) begin @(negedge clk); k++; end
    empty_b = 3'b111;
    wait_drained("non_pow2", 100);
    checks++;
    if (cnt_b !== 4'd1) begin
      errors++; $display("FAIL count_wrap: got %0d, required 1", cnt_b);
    end
  endtask

  task automatic test_reset_mid_busy();
    int k;
    en_a = 1'b1;
    #1;
    checks++;
    if (init_a !== 1'b0) begin errors++; $display("FAIL reenable_init: got %b, required 0", init_a); end
    @(negedge clk);
    exp_start_a.push_back({2'd0, 3'd1});
    empty_a = 4'b1110;
    k = 0;
    while (start_a !== 1'b1 && k < 50) begin @(negedge clk); k++; end
    @(negedge clk);
    checks++;
    if (busy_a !== 1'b1) begin errors++; $display("FAIL pre_reset_busy: got %b, required 1", busy_a); end
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if ({start_a, busy_a, sel_a, sloc_a, pop_a, init_a, cnt_a} !== {1'b0, 1'b0, 2'd0, 3'd0, 4'hF, 1'b1, 16'd0}) begin
      errors++;
      $display("FAIL reset_mid_busy: got start=%b busy=%b sel=%0d loc=%0d pop=%b init=%b cnt=%0d, required 0 0 0 0 1111 1 0",
               start_a, busy_a, sel_a, sloc_a, pop_a, init_a, cnt_a);
    end
    en_a = 1'b0;
    empty_a = 4'hF;
    wait_cycles(3);
    rst_n = 1'b1;
    wait_cycles(4);
    wait_drained("reset_mid_busy", 5);
  endtask

  initial begin
    test_reset();
    test_init();
    test_round_robin();
    test_empty_stall();
    test_disable_busy();
    test_non_pow2_wrap();
    test_reset_mid_busy();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
